// File: rtl/guess_score.sv
// Win/lose tally for the guess game: two-digit BCD counters fed by rising edges
// of the FSM's win/lose levels, shown on a 4-digit multiplexed seven-segment display.
module guess_score #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       win,
  input  logic       lose,
  input  logic       clr,
  output logic [7:0] win_cnt,
  output logic [7:0] lose_cnt,
  output logic [3:0] an,
  output logic [6:0] seg
);

  logic             win_dly_q, lose_dly_q;
  logic [7:0]       win_cnt_q, win_cnt_d;
  logic [7:0]       lose_cnt_q, lose_cnt_d;
  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       nibble;
  logic             win_evt, lose_evt, wrap;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens, ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // Active-low segments, bit order g..a.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign win_evt  = win & ~win_dly_q;
  assign lose_evt = lose & ~lose_dly_q;

  always_comb begin
    win_cnt_d  = win_cnt_q;
    lose_cnt_d = lose_cnt_q;
    if (clr) begin
      win_cnt_d  = 8'h00;
      lose_cnt_d = 8'h00;
    end else begin
      if (win_evt)  win_cnt_d  = bcd_inc(win_cnt_q);
      if (lose_evt) lose_cnt_d = bcd_inc(lose_cnt_q);
    end
  end

  assign wrap      = (ref_cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign ref_cnt_d = wrap ? '0 : ref_cnt_q + CNT_W'(1);
  assign sel_d     = wrap ? sel_q - 2'd1 : sel_q;

  // an and seg both come from sel_d so the digit enable and its pattern switch on the same edge.
  always_comb begin
    an_d   = 4'b0111;
    nibble = win_cnt_q[7:4];
    case (sel_d)
      2'd3: begin an_d = 4'b0111; nibble = win_cnt_q[7:4];  end
      2'd2: begin an_d = 4'b1011; nibble = win_cnt_q[3:0];  end
      2'd1: begin an_d = 4'b1101; nibble = lose_cnt_q[7:4]; end
      default: begin an_d = 4'b1110; nibble = lose_cnt_q[3:0]; end
    endcase
    seg_d = seg_decode(nibble);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_dly_q  <= 1'b0;
      lose_dly_q <= 1'b0;
      win_cnt_q  <= 8'h00;
      lose_cnt_q <= 8'h00;
      ref_cnt_q  <= '0;
      sel_q      <= 2'd3;
      an_q       <= 4'b0111;
      seg_q      <= 7'b1000000;
    end else begin
      win_dly_q  <= win;
      lose_dly_q <= lose;
      win_cnt_q  <= win_cnt_d;
      lose_cnt_q <= lose_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      sel_q      <= sel_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign win_cnt  = win_cnt_q;
  assign lose_cnt = lose_cnt_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_guess_score.sv
// Bench for guess_score: decimal tally model and scan-position model built from
// cycle counts, driven by directed and random win/lose/clr sequences.
module tb_guess_score;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, win, lose, clr;
  logic [7:0] win_cnt, lose_cnt;
  logic [3:0] an;
  logic [6:0] seg;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   wins_m, losses_m;
  logic pw, pl;
  int   edges;

  logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  guess_score #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .win(win), .lose(lose), .clr(clr),
    .win_cnt(win_cnt), .lose_cnt(lose_cnt), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Clock edges since reset was last released.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  function automatic logic [7:0] to_bcd(input int v);
    int m;
    m = v % 100;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  // One clock with the given input levels; the model counts rising levels unless cleared.
  task automatic tick(input logic w, input logic l, input logic c);
    win = w; lose = l; clr = c;
    @(posedge clk);
    if (c) begin
      wins_m = 0; losses_m = 0;
    end else begin
      if (w && !pw) wins_m++;
      if (l && !pl) losses_m++;
    end
    pw = w; pl = l;
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0);
      tick(0, 0, 0);
    end
    #2 rst = 1'b0;
    #1;
    n_assert++;
    if (an !== 4'b0111) begin n_fail++; $display("FAIL reset_an: got %b want 0111", an); end
    n_assert++;
    if (seg !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg: got %b want 1000000", seg); end
    n_assert++;
    if (win_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_win: got %h want 00", win_cnt); end
    n_assert++;
    if (lose_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_lose: got %h want 00", lose_cnt); end
    wins_m = 0; losses_m = 0; pw = 0; pl = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0);
      n_assert++;
      if (win_cnt !== 8'h00 || lose_cnt !== 8'h00) begin
        n_fail++; $display("FAIL idle_counts: got %h/%h want 00/00", win_cnt, lose_cnt);
      end
    end
  endtask

  task automatic test_reset_level;
    win = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    wins_m = 0; losses_m = 0; pw = 0; pl = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0);
      n_assert++;
      if (win_cnt !== 8'h01) begin n_fail++; $display("FAIL level_thru_reset: got %h want 01", win_cnt); end
    end
    tick(0, 0, 0);
  endtask

  task automatic test_win_hold;
    tick(0, 0, 1);
    tick(0, 0, 0);
    for (int r = 1; r <= 3; r++) begin
      tick(1, 0, 0);
      n_assert++;
      if (win_cnt !== to_bcd(r)) begin n_fail++; $display("FAIL win_first_edge: got %h want %h", win_cnt, to_bcd(r)); end
      for (int i = 1; i < 50; i++) begin
        tick(1, 0, 0);
        n_assert++;
        if (win_cnt !== to_bcd(wins_m)) begin n_fail++; $display("FAIL win_held: got %h want %h", win_cnt, to_bcd(wins_m)); end
      end
      for (int i = 0; i < 3; i++) tick(0, 0, 0);
    end
    n_assert++;
    if (win_cnt !== 8'h03 || lose_cnt !== 8'h00) begin
      n_fail++; $display("FAIL win_three: got %h/%h want 03/00", win_cnt, lose_cnt);
    end
  endtask

  task automatic test_lose_wrap;
    tick(0, 0, 1);
    tick(0, 0, 0);
    for (int p = 1; p <= 100; p++) begin
      tick(0, 1, 0);
      n_assert++;
      if (lose_cnt !== to_bcd(losses_m) || win_cnt !== 8'h00) begin
        n_fail++; $display("FAIL lose_pulse %0d: got %h/%h want 00/%h", p, win_cnt, lose_cnt, to_bcd(losses_m));
      end
      if (p == 9 || p == 10 || p == 99 || p == 100) begin
        n_assert++;
        if ((p == 9 && lose_cnt !== 8'h09) || (p == 10 && lose_cnt !== 8'h10) ||
            (p == 99 && lose_cnt !== 8'h99) || (p == 100 && lose_cnt !== 8'h00)) begin
          n_fail++; $display("FAIL lose_milestone %0d: got %h", p, lose_cnt);
        end
      end
      tick(0, 0, 0);
    end
  endtask

  task automatic test_simultaneous;
    tick(0, 0, 1);
    tick(0, 0, 0);
    for (int r = 1; r <= 2; r++) begin
      tick(1, 1, 0);
      n_assert++;
      if (win_cnt !== to_bcd(r) || lose_cnt !== to_bcd(r)) begin
        n_fail++; $display("FAIL simultaneous: got %h/%h want %h/%h", win_cnt, lose_cnt, to_bcd(r), to_bcd(r));
      end
      tick(0, 0, 0);
    end
  endtask

  task automatic test_clr;
    tick(1, 0, 0);
    tick(1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0);
      n_assert++;
      if (win_cnt !== 8'h00) begin n_fail++; $display("FAIL clr_held_level: got %h want 00", win_cnt); end
    end
    tick(0, 0, 0);
    tick(1, 1, 1);
    n_assert++;
    if (win_cnt !== 8'h00 || lose_cnt !== 8'h00) begin
      n_fail++; $display("FAIL clr_overrides_evt: got %h/%h want 00/00", win_cnt, lose_cnt);
    end
    tick(0, 0, 0);
  endtask

  task automatic test_display;
    int d, val;
    tick(0, 0, 1);
    tick(0, 0, 0);
    for (int i = 0; i < 37; i++) begin tick(1, 0, 0); tick(0, 0, 0); end
    for (int i = 0; i < 5; i++)  begin tick(0, 1, 0); tick(0, 0, 0); end
    n_assert++;
    if (win_cnt !== 8'h37 || lose_cnt !== 8'h05) begin
      n_fail++; $display("FAIL display_setup: got %h/%h want 37/05", win_cnt, lose_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 0);
      d = 3 - ((edges / DIV) % 4);
      case (d)
        3: val = (wins_m % 100) / 10;
        2: val = wins_m % 10;
        1: val = (losses_m % 100) / 10;
        default: val = losses_m % 10;
      endcase
      n_assert++;
      if (an !== AN_TAB[d] || seg !== SEG_TAB[val]) begin
        n_fail++; $display("FAIL display_scan: got an=%b seg=%b want an=%b seg=%b", an, seg, AN_TAB[d], SEG_TAB[val]);
      end
    end
  endtask

  task automatic test_random;
    logic w, l, c;
    w = 0; l = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) w = ~w;
      if ($urandom_range(0, 3) == 0) l = ~l;
      c = ($urandom_range(0, 40) == 0);
      tick(w, l, c);
      n_assert++;
      if (win_cnt !== to_bcd(wins_m) || lose_cnt !== to_bcd(losses_m)) begin
        n_fail++; $display("FAIL random_counts: got %h/%h want %h/%h", win_cnt, lose_cnt, to_bcd(wins_m), to_bcd(losses_m));
      end
    end
    tick(0, 0, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; win = 1'b0; lose = 1'b0; clr = 1'b0;
    wins_m = 0; losses_m = 0; pw = 0; pl = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_reset_level();
    test_win_hold();
    test_lose_wrap();
    test_simultaneous();
    test_clr();
    test_display();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/guess_score.md
Name: guess_score

Overview:
- Downstream stage of the guess-game FSM.
- Consumes the FSM's level-type win and lose flags and keeps two-digit BCD tallies of games won and games lost.
- Drives the board's 4-digit multiplexed seven-segment display: wins on the left pair of digits, losses on the right pair.
- Tallies are also exported as BCD buses for LEDs or debug.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit is lit before the scan advances (1 kHz per digit at 100 MHz). Legal range is 2 or more.
- CNT_W, 17: width of the refresh counter. Must satisfy 2^CNT_W > REFRESH_DIV.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  reset, asynchronous assert, active-low.
- win  input  1  level from the FSM; high while in its win state, possibly for many cycles.
- lose  input  1  level from the FSM; high while in its lose state.
- clr  input  1  synchronous tally clear, active-high.
- win_cnt  output  8  BCD wins: [7:4] tens, [3:0] ones.
- lose_cnt  output  8  BCD losses: [7:4] tens, [3:0] ones.
- an  output  4  digit enables, active-low, exactly one low at a time.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.

Behaviour:
- Reset (rst low, asynchronous):
  - win_cnt=8'h00, lose_cnt=8'h00.
  - Edge registers win_d=0, lose_d=0.
  - Refresh counter=0, digit select=3.
  - an=4'b0111, seg=7'b1000000 (shows "0").
  - Effective immediately, not waiting for a clock edge.
- Event detection:
  - win_evt = win & ~win_d; lose_evt = lose & ~lose_d.
  - win_d and lose_d are updated from the inputs on every clock edge.
  - A held level counts once. A level still high when rst deasserts counts once on the first clock edge.
- Tally update: at the edge where win_evt=1, win_cnt increments. The new value is visible immediately after that edge (latency 1 edge from win rising).
- BCD increment:
  - ones 9 -> 0 with a carry into tens.
  - 99 -> 00 (wrap, no saturation).
  - No non-BCD nibble is ever produced.
- Simultaneous events: win_evt and lose_evt in the same cycle increment both tallies independently.
- clr:
  - When high at an edge, both tallies go to 00 and overrides any event in that cycle.
  - win_d and lose_d still load the current inputs, so a level held through clr is not counted after clr falls.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit select advances 3 -> 2 -> 1 -> 0 -> 3.
  - Scan is free-running and unaffected by clr or by events.
- Digit mapping:
  - sel 3: an=0111, win tens.
  - sel 2: an=1011, win ones.
  - sel 1: an=1101, lose tens.
  - sel 0: an=1110, lose ones.
- Display timing: an and seg are registered and derived from the same select value, so they change together (no ghosting). A tally change appears on the display no later than the next time that digit is scanned.
- Decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble = 1111111 (blank); cannot occur.
- No leading-zero blanking; the decimal point is not driven.

Test Plan:
- Reset and hold checks:
  - Assert rst low mid-simulation -> all outputs immediately reach their reset values (an=0111, seg=1000000, counts 00).
  - Release rst, apply no inputs -> counts stay 00.
- Pulse win high for 50 cycles -> win_cnt=8'h01 after the first edge of win and stays 01. Repeat 3 times -> 8'h03, lose_cnt stays 00.
- Generate 99 lose pulses, then 1 more -> lose_cnt reads 8'h09 after 9 pulses, 8'h10 after 10, 8'h99 after 99, then 8'h00.
- Raise win and lose on the same edge -> both tallies +1 on that edge.
- Hold win high, assert clr for one cycle, release clr, keep win high 10 more cycles -> win_cnt=00 and stays 00.
- With REFRESH_DIV=4, win_cnt=8'h37, lose_cnt=8'h05, observe 16 cycles:
  - an sequence is 0111, 1011, 1101, 1110, each held 4 cycles.
  - seg values are 0110000, 1111000, 1000000, 0010010.
  - an and seg change on the same edges.
